// File: rtl/stagepipe_pkg.sv
// rtl/stagepipe_pkg.sv - opcodes, instruction field layout, NOP word and FSM encoding for the instruction loader
package stagepipe_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam int OP_LSB  = 30;
    localparam int RS1_LSB = 25;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 0;

    // Writes r0, which the pipeline treats as a discard.
    localparam logic [31:0] NOP_WORD = {OP_NOP, 30'b0};

    localparam int MEM_WORDS_DEF = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_PAD  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_fields_t;

    function automatic logic [31:0] encode_instr(input instr_fields_t f);
        logic [31:0] w;
        w = '0;
        w[OP_LSB  +: 2] = f.op;
        w[RS1_LSB +: 5] = f.rs1;
        w[RS2_LSB +: 5] = f.rs2;
        w[RD_LSB  +: 5] = f.rd;
        return w;
    endfunction

endpackage

// File: rtl/stagepipe_sync_fifo.sv
// rtl/stagepipe_sync_fifo.sv - registered synchronous FIFO; head entry readable combinationally while held
module stagepipe_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [PW:0] FULL_CNT = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/stagepipe_instr_loader.sv
// rtl/stagepipe_instr_loader.sv - packs instruction fields and loads instruction memory; STAGEPIPE_LOADER_PAD_EN fills the tail with NOPs
module stagepipe_instr_loader
    import stagepipe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_WORDS  = MEM_WORDS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_op,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [4:0]                   in_rd,
    input  logic                         in_last,
    input  logic                         clear,
    output logic                         mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_ready,
    output logic                         pipe_rst,
    output logic                         done,
    output logic [$clog2(MEM_WORDS):0]   words
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = AW + 1;
    localparam logic [AW:0]   CNT_MAX   = CW'(MEM_WORDS);
    localparam logic [AW:0]   CNT_LAST  = CW'(MEM_WORDS - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_WORDS - 1);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] addr_q;
    logic [AW:0]   words_q;
    logic [AW:0]   acc_cnt_q;
    logic          last_seen_q;
    logic          pipe_rst_q;
    logic          done_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_rdata;
    logic [31:0]   in_word;
    logic          accept;
    logic          accept_last;
    logic          pad_active;
    logic          wr_done;

    assign in_word = encode_instr('{op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd});

    // rst is folded in so the stream sees not-ready for the whole reset, not just after it.
    assign in_ready = !rst
                    && (state_q == ST_IDLE || state_q == ST_LOAD)
                    && !fifo_full && !last_seen_q && (acc_cnt_q < CNT_MAX);
    assign accept      = in_valid && in_ready;
    assign accept_last = in_last || (acc_cnt_q == CNT_LAST);

`ifdef STAGEPIPE_LOADER_PAD_EN
    assign pad_active = (state_q == ST_PAD);
`else
    assign pad_active = 1'b0;
`endif

    assign mem_we    = !fifo_empty || pad_active;
    assign mem_wdata = pad_active ? NOP_WORD : (fifo_empty ? 32'h0 : fifo_rdata);
    assign mem_addr  = addr_q;
    assign wr_done   = mem_we && mem_ready;
    assign pipe_rst  = pipe_rst_q;
    assign done      = done_q;
    assign words     = words_q;

    stagepipe_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (in_word),
        .pop   (wr_done && !fifo_empty),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: begin
                // An empty FIFO after the last accept means every program word has landed.
                if (last_seen_q && fifo_empty) begin
`ifdef STAGEPIPE_LOADER_PAD_EN
                    state_d = (words_q == CNT_MAX) ? ST_DONE : ST_PAD;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef STAGEPIPE_LOADER_PAD_EN
            ST_PAD:  if (wr_done && words_q == CNT_LAST) state_d = ST_DONE;
`endif
            ST_DONE: if (clear) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            words_q     <= '0;
            acc_cnt_q   <= '0;
            last_seen_q <= 1'b0;
            pipe_rst_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pipe_rst_q <= (state_d != ST_DONE);
            done_q     <= (state_d == ST_DONE);
            if (state_q == ST_DONE && clear) begin
                addr_q      <= '0;
                words_q     <= '0;
                acc_cnt_q   <= '0;
                last_seen_q <= 1'b0;
            end else begin
                if (accept) begin
                    acc_cnt_q <= acc_cnt_q + 1'b1;
                    if (accept_last) last_seen_q <= 1'b1;
                end
                if (wr_done) begin
                    words_q <= words_q + 1'b1;
                    if (addr_q != ADDR_LAST) addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

endmodule
